// File: rtl/sub_chunked_seq_if.sv
// Chunk-level handshake bundle for sub_chunked_seq: operand chunks in, difference chunk and
// framing/status out.
interface sub_chunked_seq_if #(
    parameter int unsigned W = 8
) ();
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         valid;
    logic         last;
    logic         busy;
    logic         done;
    logic         borrow_out;
    logic         eq;

    modport master (
        output start, a, b,
        input  c, valid, last, busy, done, borrow_out, eq
    );

    modport slave (
        input  start, a, b,
        output c, valid, last, busy, done, borrow_out, eq
    );
endinterface

// File: rtl/sub_chunked_seq.sv
// Multi-cycle N-bit subtractor, one W = N/CC bit chunk per cycle, LS chunk first.
// Optional running equality flag enabled by defining SUB_CHUNKED_EQ_FLAG_EN.
module sub_chunked_seq #(
    parameter int unsigned N  = 128,
    parameter int unsigned CC = 16
) (
    input logic              clk,
    input logic              rst,
    sub_chunked_seq_if.slave bus
);
    localparam int unsigned W    = N / CC;
    localparam int unsigned CntW = (CC > 1) ? $clog2(CC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CC - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            borrow_q;
    logic            borrow_out_q;
    logic            done_q;
    logic            active;
    logic            last_chunk;
    logic            bin;
    logic            bnext;
    logic [W:0]      diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= last_chunk;
            if (active) borrow_q <= bnext;
            // Final borrow becomes visible together with done.
            if (last_chunk) borrow_out_q <= bnext;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cnt_d   = (CC == 1) ? '0 : CntW'(1);
                    state_d = (CC == 1) ? StIdle : StRun;
                end
            end
            StRun: begin
                if (last_chunk) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.busy = (state_q == StRun);
        // start in RUN is a don't-care; in IDLE it opens chunk 0 with a clean borrow.
        active     = (state_q == StRun) | bus.start;
        bin        = (state_q == StRun) ? borrow_q : 1'b0;
        // cnt_q is 0 in IDLE, so this also covers the CC == 1 single-chunk case.
        last_chunk = active & (cnt_q == CntLast);
        diff       = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bin};
        bnext      = diff[W];
        bus.c          = diff[W-1:0];
        bus.valid      = active;
        bus.last       = last_chunk;
        bus.done       = done_q;
        bus.borrow_out = borrow_out_q;
    end

`ifdef SUB_CHUNKED_EQ_FLAG_EN
    logic zq_q;
    logic zq_d;
    logic eq_q;

    assign zq_d = ((state_q == StRun) ? zq_q : 1'b1) & (diff[W-1:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zq_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            if (active) zq_q <= zq_d;
            if (last_chunk) eq_q <= zq_d & ~bnext;
        end
    end

    assign bus.eq = eq_q;
`else
    assign bus.eq = 1'b0;
`endif
endmodule

// File: doc/sub_chunked_seq.md
# sub_chunked_seq

Multi-cycle N-bit subtractor for the sequential arithmetic netlist set: computes c = a − b over CC clock cycles, consuming one W = N/CC bit chunk of each operand per cycle, least-significant chunk first, and producing the matching difference chunk in the same cycle. It is the inverse-operation companion of the chunked sequential adder. A registered borrow links consecutive chunks. A small controller adds explicit start/last/done framing, so a garbling harness can sequence back-to-back operations without external counters.

## Interface
Parameters:
- N, 128, total operand width in bits
- CC, 16, number of chunk cycles per operation; N must be divisible by CC; W = N/CC

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin operation; current cycle carries chunk 0
- a  input  W  minuend chunk for the current cycle
- b  input  W  subtrahend chunk for the current cycle
- c  output  W  difference chunk, combinational from a, b and borrow
- valid  output  1  c is a live chunk this cycle
- last  output  1  current chunk is chunk CC−1
- busy  output  1  an operation is in progress (RUN state)
- done  output  1  one-cycle pulse the cycle after the last chunk
- borrow_out  output  1  final borrow (1 ⇔ a < b unsigned), held until next start
- eq  output  1  a == b over all N bits, held until next start (see Configuration)

## Operation
- State machine: IDLE, RUN. Chunk counter cnt, width clog2(CC) (minimum 1), plus borrow register bq.
- Effective borrow-in bin = 0 when (IDLE and start), else bq.
- c = (a − b − bin) mod 2^W; bnext = 1 when a < b + bin (compare at W+1 bits).
- IDLE: valid = start. If start: the cycle processes chunk 0; bq ← bnext; cnt ← 1; go to RUN. When CC = 1 the chunk is also last: last = 1, stay in IDLE, done next cycle.
- RUN: valid = 1, busy = 1; bq ← bnext; cnt increments each cycle. last = (cnt == CC−1). On last: cnt ← 0, go to IDLE.
- start while in RUN is ignored. It neither restarts nor perturbs cnt or bq.
- Final result: on the cycle after last, borrow_out ← bq (the borrow out of chunk CC−1) and done = 1.
- start in the same cycle as done is accepted normally. borrow_out and eq then keep their old values until the new operation's done.
- Reset (any time, including mid-operation): state IDLE; cnt = 0; bq = 0; done = 0; borrow_out = 0; eq = 0. An operation interrupted by reset is abandoned. The next start gets fresh bin = 0.

## Timing
- Zero-latency datapath: c for chunk k is valid in the same cycle a/b chunk k is presented.
- An operation takes exactly CC cycles of valid, starting on the start cycle.
- done and the updated borrow_out/eq appear at cycle CC after start (start cycle = 0).
- Maximum throughput is one operation per CC cycles with start asserted on each done cycle.
- Outputs after reset: valid = start (combinational), last = 0 unless CC = 1, busy = 0, done = 0, borrow_out = 0, eq = 0. c is combinational.

## Configuration
- SUB_CHUNKED_EQ_FLAG_EN defined: add a running register zq.
  - On the start cycle: zq ← (c == 0).
  - Each following chunk: zq ← zq & (c == 0).
  - On the done cycle: eq ← zq & ~bq_final.
  - On reset: zq = 0 and eq = 0.
- Not defined: zq does not exist, and eq is tied to constant 0. The block has no other difference.

## Test plan
N = 128, CC = 16, W = 8 throughout.
- a = 5, b = 3 (chunk 0 only, all other chunks 0) -> c chunk 0 = 0x02, chunks 1–15 = 0x00; done at cycle 16; borrow_out = 0; eq = 0.
- a = 0, b = 1 -> every c chunk = 0xFF; borrow_out = 1; eq = 0.
- a = b = random 128-bit value -> all chunks 0x00; borrow_out = 0; eq = 1 with macro, eq = 0 without.
- Borrow ripple: a = 2^64 (chunk 8 = 0x01), b = 1 -> chunks 0–7 = 0xFF, chunk 8 = 0x00, chunks 9–15 = 0x00; borrow_out = 0.
- Reset mid-operation: assert rst during chunk 7 of the a = 0, b = 1 case -> busy, done, borrow_out and eq drop to 0 immediately. Then start a = 5, b = 3 -> result identical to the first scenario, with no stale borrow.
- start pulsed during RUN at chunk 4 -> ignored, and the result is unchanged. A second start on the done cycle -> accepted, with valid = 1 that cycle and a correct second result 16 cycles later.
